cond_unit: RTL
==============

# cond_unit

Conditional-execution unit for the single-cycle ARM core: the consumer of the ALU decoder's `flag_w` output and the ALU's NZCV result. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it. It gates the main decoder's unconditioned write/branch controls and counts executed and squashed instructions for debug. It sits between the control decoders and the register file, data memory and PC mux.

## Interface
Parameters:
- `CNT_W`, 16: width of each instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `en`  in  1  instruction valid / not stalled; 0 freezes all state and forces write enables low.
- `cond`  in  4  instruction bits [31:28].
- `alu_flags`  in  4  {N,Z,C,V} from the ALU for the current instruction.
- `flag_w`  in  2  from the ALU decoder: [1] = update N,Z; [0] = update C,V.
- `pcs`, `reg_w`, `mem_w`  in  1 each  unconditioned controls from the main decoder.
- `pc_src`, `reg_write`, `mem_write`  out  1 each  gated controls.
- `cond_ex`  out  1  condition passes against the current flags.
- `flags`  out  4  registered {N,Z,C,V}.
- `exec_cnt`, `squash_cnt`  out  CNT_W each  executed / squashed instruction counts.

## Operation
- Conditions are evaluated on registered flags (N,Z,C,V):
  - 0000 EQ: Z; 0001 NE: !Z; 0010 CS: C; 0011 CC: !C.
  - 0100 MI: N; 0101 PL: !N; 0110 VS: V; 0111 VC: !V.
  - 1000 HI: C&!Z; 1001 LS: !C|Z; 1010 GE: N==V; 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V); 1101 LE: Z|(N!=V); 1110 AL: 1.
  - 1111: never (cond_ex=0); this core treats it as reserved.
- Gating: `pc_src = pcs & cond_ex & en & reset_n`. `reg_write` and `mem_write` use the same form with `reg_w` and `mem_w`.
- Flag update when `reset_n=1`, `en=1` and `cond_ex=1`:
  - `flag_w[1]` set: N,Z <= alu_flags[3:2].
  - `flag_w[0]` set: C,V <= alu_flags[1:0].
  - The two halves are independent. `flag_w=10` (logical op with S) leaves C,V unchanged. `flag_w=00` changes nothing.
  - A squashed instruction never updates flags, regardless of `flag_w`.
- Counters:
  - `en=1`, `cond_ex=1`: `exec_cnt` +1.
  - `en=1`, `cond_ex=0`: `squash_cnt` +1.
  - `en=0`: neither changes.
  - Both wrap modulo 2^CNT_W with no saturation or overflow flag.
- Reset (`reset_n=0` at an edge): flags, `exec_cnt` and `squash_cnt` are cleared to 0. This takes priority over `en` and any flag write in the same cycle, including mid-sequence.

## Timing
- `cond_ex` and the gated outputs are combinational from `cond`, registered flags, `en` and the unconditioned controls. Zero latency, same cycle.
- Flag writes become visible on `flags` and in `cond_ex` one cycle after the instruction that sets them. The instruction that sets flags is evaluated against the old flags.
- Counter increments become visible one cycle after the counted instruction.
- Output values:
  - After reset: `flags=0000`, both counters 0.
  - While `reset_n=0`: `pc_src`, `reg_write` and `mem_write` are 0; `cond_ex` still reflects `cond` against the registered flags.
- `en=0` for N cycles: all state holds exactly, the gated outputs are 0, and evaluation resumes unchanged when `en` returns to 1.
- `alu_flags` is sampled only on the update edge; its value in other cycles is don't-care.

## Test plan
- Reset: hold `reset_n=0` two cycles with `en=1`, `cond=1110`, `reg_w=1`, `flag_w=11`, `alu_flags=1111` -> `flags=0000`, counters 0, `reg_write=0` throughout.
- SUBS then BNE:
  - cycle 0: `cond=1110`, `flag_w=11`, `alu_flags=0110`.
  - cycle 1: `flags=0110`; `cond=0001`, `pcs=1` -> `cond_ex=0`, `pc_src=0`, `squash_cnt=1` next cycle.
  - with `cond=0000` instead -> `pc_src=1`.
- Partial update: with `flags=0011`, apply `flag_w=10`, `alu_flags=1000`, AL -> `flags=1011` next cycle.
- Squashed S-instruction: with `flags=0000`, apply `cond=0000`, `flag_w=11`, `alu_flags=0100` -> flags stay `0000`, `mem_write=0` despite `mem_w=1`.
- All 16 condition codes: sweep each code against all 16 flag values -> `cond_ex` matches the table; 1111 is always 0.
- Stall and wrap:
  - `CNT_W=4`: 16 executed AL instructions -> `exec_cnt` wraps to 0.
  - `en=0` for 3 cycles mid-stream with `flag_w=11` -> flags and counts unchanged.
  - assert `reset_n=0` mid-stream -> everything cleared next edge.

Source files
------------

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition-code evaluation, control gating and
// executed/squashed instruction counters for the single-cycle ARM core.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q, exec_d, squash_q, squash_d;
    logic             n, z, c, v, base, go, upd;

    assign {n, z, c, v} = flags_q;

    // Odd codes are the complement of the even code below them; 1111 never passes.
    always_comb begin
        base = cond[3:1] == 3'd0 ? z :
               cond[3:1] == 3'd1 ? c :
               cond[3:1] == 3'd2 ? n :
               cond[3:1] == 3'd3 ? v :
               cond[3:1] == 3'd4 ? c & ~z :
               cond[3:1] == 3'd5 ? n == v :
               cond[3:1] == 3'd6 ? ~z & (n == v) : 1'b1;
        cond_ex = cond == 4'hF ? 1'b0 : base ^ cond[0];
    end

    assign go  = cond_ex & en & reset_n;
    assign upd = en & cond_ex;

    always_comb begin
        flags_d[3:2] = upd & flag_w[1] ? alu_flags[3:2] : flags_q[3:2];
        flags_d[1:0] = upd & flag_w[0] ? alu_flags[1:0] : flags_q[1:0];
        exec_d       = upd ? exec_q + 1'b1 : exec_q;
        squash_d     = en & ~cond_ex ? squash_q + 1'b1 : squash_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q  <= '0;
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            flags_q  <= flags_d;
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign pc_src     = pcs & go;
    assign reg_write  = reg_w & go;
    assign mem_write  = mem_w & go;
    assign flags      = flags_q;
    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;
endmodule
